// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage; pairs request records with in-order data_ok responses and feeds decode
module if_stage #(
    parameter int PFS_BUS_WD = 104,
    parameter int FS_BUS_WD  = 103
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pfs_to_fs_valid,
    input  logic [PFS_BUS_WD-1:0] pfs_to_fs_bus,
    output logic                  fs_allowin,
    output logic                  fs_valid,
    output logic                  fs_inst_unable,
    input  logic                  pfs_inst_waiting,
    input  logic                  inst_sram_data_ok,
    input  logic [31:0]           inst_sram_rdata,
    input  logic                  ds_allowin,
    output logic                  fs_to_ds_valid,
    output logic [FS_BUS_WD-1:0]  fs_to_ds_bus,
    input  logic                  do_flush
);
    // only the fields forwarded to decode are latched: {tlb_refill, excode, badvaddr, ex, pc}
    logic [70:0] r_fs_bus;
    logic        r_fs_valid;
    logic        r_inst_ok;
    logic [31:0] r_inst;
    logic [1:0]  r_drop_cnt;
    logic        w_fs_ex;
    logic        w_fs_waiting;
    logic        w_drop;
    logic        w_take_data;
    logic        w_ready_go;
    logic        w_accept;
    logic        w_orphan_fs;
    logic [31:0] w_fs_inst;

    assign w_fs_ex        = r_fs_bus[32];
    assign w_fs_waiting   = r_fs_valid && !r_inst_ok && !w_fs_ex;
    assign w_drop         = inst_sram_data_ok && (r_drop_cnt != 2'd0);
    assign w_take_data    = inst_sram_data_ok && (r_drop_cnt == 2'd0) && w_fs_waiting;
    assign w_ready_go     = w_fs_ex || r_inst_ok || w_take_data;
    assign fs_allowin     = !r_fs_valid || (w_ready_go && ds_allowin);
    assign fs_valid       = r_fs_valid;
    assign fs_to_ds_valid = r_fs_valid && w_ready_go && !do_flush;
    assign fs_inst_unable = (r_drop_cnt == 2'd0) && !w_fs_waiting;
    assign w_accept       = pfs_to_fs_valid && fs_allowin && !do_flush;
    // a flushed wait whose data is not arriving now leaves an orphan response behind
    assign w_orphan_fs    = w_fs_waiting && !w_take_data;
    assign w_fs_inst      = w_fs_ex ? 32'd0 : (r_inst_ok ? r_inst : inst_sram_rdata);
    assign fs_to_ds_bus   = {r_fs_bus[70], r_fs_bus[69:65], r_fs_bus[64:33], r_fs_bus[32], w_fs_inst, r_fs_bus[31:0]};

    // record slot: accept, hold captured instruction across decode stalls, clear on flush
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fs_valid <= 1'b0;
            r_fs_bus   <= '0;
            r_inst     <= '0;
            r_inst_ok  <= 1'b0;
        end else if (do_flush) begin
            r_fs_valid <= 1'b0;
            r_inst_ok  <= 1'b0;
        end else if (w_accept) begin
            r_fs_valid <= 1'b1;
            r_fs_bus   <= {pfs_to_fs_bus[103], pfs_to_fs_bus[69:0]};
            r_inst     <= pfs_to_fs_bus[101:70];
            r_inst_ok  <= pfs_to_fs_bus[102] || pfs_to_fs_bus[32];
        end else if (w_take_data && !(ds_allowin && r_fs_valid)) begin
            r_inst     <= inst_sram_rdata;
            r_inst_ok  <= 1'b1;
        end else if (fs_allowin) begin
            r_fs_valid <= 1'b0;
        end
    end

    // count responses still owed to requests cancelled by a flush
    always_ff @(posedge clk) begin
        if (reset) r_drop_cnt <= 2'd0;
        else r_drop_cnt <= r_drop_cnt - {1'b0, w_drop}
                          + (do_flush ? ({1'b0, w_orphan_fs} + {1'b0, pfs_inst_waiting}) : 2'd0);
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and random checks of if_stage against a record-slot reference model
module tb_if_stage;
    logic         clk = 1'b0;
    logic         reset;
    logic         pfs_to_fs_valid;
    logic [103:0] pfs_to_fs_bus;
    logic         fs_allowin;
    logic         fs_valid;
    logic         fs_inst_unable;
    logic         pfs_inst_waiting;
    logic         inst_sram_data_ok;
    logic [31:0]  inst_sram_rdata;
    logic         ds_allowin;
    logic         fs_to_ds_valid;
    logic [102:0] fs_to_ds_bus;
    logic         do_flush;

    int errors = 0;
    int checks = 0;

    // reference model: one record slot plus a count of orphaned responses
    bit           m_full;
    logic [103:0] m_rec;
    bit           m_has_inst;
    logic [31:0]  m_inst;
    int           m_orphans;

    if_stage dut (
        .clk(clk), .reset(reset),
        .pfs_to_fs_valid(pfs_to_fs_valid), .pfs_to_fs_bus(pfs_to_fs_bus),
        .fs_allowin(fs_allowin), .fs_valid(fs_valid), .fs_inst_unable(fs_inst_unable),
        .pfs_inst_waiting(pfs_inst_waiting), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata), .ds_allowin(ds_allowin),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus), .do_flush(do_flush)
    );

    always #5 clk = ~clk;

    function automatic logic [103:0] mk(input logic [31:0] pc, input logic [31:0] inst, input logic ok,
                                        input logic ex, input logic [4:0] excode, input logic [31:0] bad,
                                        input logic refill);
        return {refill, ok, inst, excode, bad, ex, pc};
    endfunction

    task automatic chk(input string tag, input logic [102:0] obs, input logic [102:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // compare against the model for the current cycle, advance the model, then cross the clock edge
    task automatic tick();
        bit ex, needs_data, orphan_resp, gets_data, ready, handed, slot_free;
        logic [31:0] inst;
        ex          = m_full && m_rec[32] == 1'b1;
        needs_data  = m_full && !m_has_inst && !ex;
        orphan_resp = inst_sram_data_ok && m_orphans > 0;
        gets_data   = inst_sram_data_ok && m_orphans == 0 && needs_data;
        ready       = m_full && (ex || m_has_inst || gets_data);
        handed      = ready && ds_allowin && !do_flush;
        slot_free   = !m_full || (ready && ds_allowin);
        inst        = ex ? 32'd0 : (m_has_inst ? m_inst : inst_sram_rdata);
        chk("m_fs_valid", 103'(fs_valid), 103'(m_full));
        chk("m_allowin", 103'(fs_allowin), 103'(slot_free));
        chk("m_to_ds_valid", 103'(fs_to_ds_valid), 103'(ready && !do_flush));
        chk("m_inst_unable", 103'(fs_inst_unable), 103'(m_orphans == 0 && !needs_data));
        if (ready && !do_flush)
            chk("m_bus", fs_to_ds_bus, {m_rec[103], m_rec[69:65], m_rec[64:33], m_rec[32], inst, m_rec[31:0]});
        if (orphan_resp) m_orphans--;
        if (do_flush) begin
            m_orphans += (needs_data && !gets_data) ? 1 : 0;
            m_orphans += pfs_inst_waiting ? 1 : 0;
            m_full = 0;
            m_has_inst = 0;
        end else if (slot_free) begin
            m_full = pfs_to_fs_valid;
            if (pfs_to_fs_valid) begin
                m_rec      = pfs_to_fs_bus;
                m_has_inst = pfs_to_fs_bus[102] || pfs_to_fs_bus[32];
                m_inst     = pfs_to_fs_bus[101:70];
            end
        end else if (gets_data && !handed) begin
            m_has_inst = 1;
            m_inst     = inst_sram_rdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        tick();
    endtask

    initial begin
        reset = 1; pfs_to_fs_valid = 0; pfs_to_fs_bus = '0; pfs_inst_waiting = 0;
        inst_sram_data_ok = 0; inst_sram_rdata = '0; ds_allowin = 1; do_flush = 0;
        m_full = 0; m_rec = '0; m_has_inst = 0; m_inst = '0; m_orphans = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("rst_fs_valid", 103'(fs_valid), 103'(0));
        chk("rst_to_ds_valid", 103'(fs_to_ds_valid), 103'(0));
        chk("rst_allowin", 103'(fs_allowin), 103'(1));
        chk("rst_inst_unable", 103'(fs_inst_unable), 103'(1));
        chk("rst_bus", fs_to_ds_bus, 103'(0));
        tick();

        // record already carrying its instruction
        pfs_to_fs_valid = 1;
        pfs_to_fs_bus = mk(32'hbfc00000, 32'h24010001, 1, 0, 0, 0, 0);
        step();
        pfs_to_fs_valid = 0;
        @(negedge clk);
        chk("carried_valid", 103'(fs_to_ds_valid), 103'(1));
        chk("carried_pc", 103'(fs_to_ds_bus[31:0]), 103'(32'hbfc00000));
        chk("carried_inst", 103'(fs_to_ds_bus[63:32]), 103'(32'h24010001));
        tick();

        // late data bypassed straight to decode
        pfs_to_fs_valid = 1;
        pfs_to_fs_bus = mk(32'hbfc00004, 32'h0, 0, 0, 0, 0, 0);
        step();
        pfs_to_fs_valid = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("late_unable", 103'(fs_inst_unable), 103'(0));
            chk("late_not_valid", 103'(fs_to_ds_valid), 103'(0));
            tick();
        end
        inst_sram_data_ok = 1; inst_sram_rdata = 32'h8c220000;
        @(negedge clk);
        chk("late_valid", 103'(fs_to_ds_valid), 103'(1));
        chk("late_inst", 103'(fs_to_ds_bus[63:32]), 103'(32'h8c220000));
        tick();
        inst_sram_data_ok = 0;

        // data arriving while decode stalls is held
        pfs_to_fs_valid = 1; ds_allowin = 0;
        pfs_to_fs_bus = mk(32'hbfc00004, 32'h0, 0, 0, 0, 0, 0);
        step();
        pfs_to_fs_valid = 0;
        inst_sram_data_ok = 1; inst_sram_rdata = 32'h8c220000;
        step();
        inst_sram_data_ok = 0;
        for (int i = 0; i < 4; i++) begin
            inst_sram_rdata = $urandom;
            @(negedge clk);
            chk("stall_valid", 103'(fs_to_ds_valid), 103'(1));
            chk("stall_inst", 103'(fs_to_ds_bus[63:32]), 103'(32'h8c220000));
            chk("stall_allowin", 103'(fs_allowin), 103'(0));
            tick();
        end
        ds_allowin = 1;
        step();

        // flush with two responses outstanding; the record offered in the flush cycle is refused
        pfs_to_fs_valid = 1;
        pfs_to_fs_bus = mk(32'hbfc00008, 32'h0, 0, 0, 0, 0, 0);
        step();
        pfs_to_fs_bus = mk(32'hbfc0000c, 32'h11111111, 1, 0, 0, 0, 0);
        do_flush = 1; pfs_inst_waiting = 1;
        @(negedge clk);
        chk("flush_to_ds_valid", 103'(fs_to_ds_valid), 103'(0));
        tick();
        do_flush = 0; pfs_inst_waiting = 0; pfs_to_fs_valid = 0;
        inst_sram_data_ok = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("drop_fs_valid", 103'(fs_valid), 103'(0));
            chk("drop_unable", 103'(fs_inst_unable), 103'(0));
            tick();
        end
        @(negedge clk);
        chk("third_unable", 103'(fs_inst_unable), 103'(1));
        tick();
        inst_sram_data_ok = 0;

        // flush coincident with the awaited data_ok leaves no orphan
        pfs_to_fs_valid = 1;
        pfs_to_fs_bus = mk(32'hbfc00010, 32'h0, 0, 0, 0, 0, 0);
        step();
        pfs_to_fs_valid = 0; inst_sram_data_ok = 1; do_flush = 1;
        @(negedge clk);
        chk("coinc_to_ds_valid", 103'(fs_to_ds_valid), 103'(0));
        tick();
        inst_sram_data_ok = 0; do_flush = 0;
        @(negedge clk);
        chk("coinc_unable", 103'(fs_inst_unable), 103'(1));
        tick();

        // exception record never waits for data
        pfs_to_fs_valid = 1;
        pfs_to_fs_bus = mk(32'hbfc00002, 32'hdeadbeef, 0, 1, 5'h04, 32'hbfc00002, 0);
        step();
        pfs_to_fs_valid = 0;
        @(negedge clk);
        chk("ex_valid", 103'(fs_to_ds_valid), 103'(1));
        chk("ex_inst", 103'(fs_to_ds_bus[63:32]), 103'(0));
        chk("ex_excode", 103'(fs_to_ds_bus[101:97]), 103'(5'h04));
        chk("ex_badvaddr", 103'(fs_to_ds_bus[96:65]), 103'(32'hbfc00002));
        chk("ex_unable", 103'(fs_inst_unable), 103'(1));
        tick();

        // random traffic; flushes only when no orphans are owed so the count stays within 2
        for (int i = 0; i < 500; i++) begin
            ds_allowin        = ($urandom % 4) != 0;
            pfs_to_fs_valid   = $urandom % 2;
            pfs_to_fs_bus     = mk($urandom, $urandom, 1'($urandom % 2), 1'(($urandom % 6) == 0),
                                   5'($urandom), $urandom, 1'($urandom % 2));
            inst_sram_data_ok = ($urandom % 3) == 0;
            inst_sram_rdata   = $urandom;
            pfs_inst_waiting  = $urandom % 2;
            do_flush          = (m_orphans == 0) && (($urandom % 12) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It sits directly downstream of the instruction-request stage and upstream of decode. It accepts a request record that may or may not already carry its instruction word, and waits for the in-order `inst_sram_data_ok` response when needed. It tells the request stage which responses belong to it, drops responses orphaned by a pipeline flush, and hands {pc, inst, exception info} to decode.

## Interface
- `PFS_BUS_WD`, 104: width of the input bus. Fields, MSB first: tlb_refill[103], inst_ok[102], inst[101:70], excode[69:65], badvaddr[64:33], ex[32], pc[31:0].
- `FS_BUS_WD`, 103: width of the output bus. Fields, MSB first: tlb_refill[102], excode[101:97], badvaddr[96:65], ex[64], inst[63:32], pc[31:0].
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `pfs_to_fs_valid` in 1: request-stage record valid.
- `pfs_to_fs_bus` in PFS_BUS_WD: request-stage record.
- `fs_allowin` out 1: this stage can accept a record this cycle.
- `fs_valid` out 1: this stage holds a valid record.
- `fs_inst_unable` out 1: high means this stage will not consume a data_ok arriving this cycle, so the request stage may take it.
- `pfs_inst_waiting` in 1: the request stage has an accepted address whose data has not returned.
- `inst_sram_data_ok` in 1: instruction response strobe.
- `inst_sram_rdata` in 32: instruction response data.
- `ds_allowin` in 1: decode can accept a record.
- `fs_to_ds_valid` out 1: record to decode is valid.
- `fs_to_ds_bus` out FS_BUS_WD: record to decode.
- `do_flush` in 1: exception or eret flush. Kills the contents of this stage in the same cycle.

## Operation
- Registers:
  - `fs_valid`
  - `fs_bus_r`: the latched input bus.
  - `inst_r` and `inst_r_ok`: the captured instruction word and its valid flag.
  - `drop_cnt[1:0]`: count of responses still owed to cancelled requests.
- Stage handshake:
  - `fs_ready_go = fs_ex || inst_r_ok || take_data`.
  - `fs_allowin = !fs_valid || (fs_ready_go && ds_allowin)`.
  - `fs_to_ds_valid = fs_valid && fs_ready_go && !do_flush`.
- Accept: when `pfs_to_fs_valid && fs_allowin && !do_flush`:
  - `fs_valid <= 1` and `fs_bus_r <= pfs_to_fs_bus`.
  - `inst_r <= bus inst` and `inst_r_ok <= bus inst_ok || bus ex`.
- Otherwise, when `fs_allowin`, `fs_valid <= 0`.
- Waiting condition: `fs_waiting = fs_valid && !inst_r_ok && !fs_ex`.
- Response routing (responses return in request order):
  - If `drop_cnt != 0`, a data_ok is dropped and `drop_cnt` decrements.
  - Else if `fs_waiting`, the data_ok is consumed here (`take_data`).
  - Else it belongs to the request stage.
  - `fs_inst_unable = (drop_cnt == 0) && !fs_waiting`.
- Capture: if `take_data && !(ds_allowin && fs_valid)`, then `inst_r <= inst_sram_rdata` and `inst_r_ok <= 1`. Output inst selection:
  - `fs_inst = inst_r_ok ? inst_r : inst_sram_rdata`.
  - When `fs_ex`, inst is forced to 0.
- Flush: `do_flush` sets `fs_valid <= 0` and `inst_r_ok <= 0`. Then `drop_cnt_next = drop_cnt - dec + a + b`, where:
  - `dec = inst_sram_data_ok && drop_cnt != 0`.
  - `a = fs_waiting && !take_data`.
  - `b = pfs_inst_waiting`.
  - Maximum value is 2; a 2-bit counter never overflows.
- Non-flush cycles: `drop_cnt_next = drop_cnt - dec`.
- Output bus fields are taken from `fs_bus_r`, with inst replaced by `fs_inst`.

## Timing
- Reset values: `fs_valid=0`, `fs_to_ds_valid=0`, `fs_allowin=1`, `fs_inst_unable=1`, `drop_cnt=0`, `inst_r_ok=0`, `fs_to_ds_bus=0`.
- Latency:
  - Record arriving with inst_ok and `ds_allowin=1`: `fs_to_ds_valid` is high the cycle after acceptance.
  - Record arriving without inst: `fs_to_ds_valid` rises combinationally in the cycle data_ok arrives (bypass).
- Stall: if data arrives while `ds_allowin=0`, it is held in `inst_r`. The record stays until `ds_allowin`, with no re-request.
- Flush cycle: `fs_to_ds_valid=0`. No record is accepted in that cycle, even if `pfs_to_fs_valid=1`.
- Simultaneous data_ok and flush:
  - With `drop_cnt == 0` and `fs_waiting`: the response is consumed and discarded, so `a = 0`.
  - With `drop_cnt != 0`: the response decrements the counter.
- While `drop_cnt != 0`, `fs_inst_unable=0`, so the request stage never sees a stale response.
- Reset mid-wait: all state clears and outstanding responses are not tracked. The memory interface is reset simultaneously.

## Test plan
- **Inst-carried record:** accept pc=0xbfc00000, inst_ok=1, inst=0x24010001 with `ds_allowin=1` → next cycle `fs_to_ds_valid=1`, bus pc=0xbfc00000, inst=0x24010001.
- **Late data:** accept pc=0xbfc00004 with inst_ok=0; data_ok with rdata=0x8c220000 three cycles later →
  - `fs_inst_unable=0` until then.
  - Valid rises in the data_ok cycle with inst=0x8c220000.
- **Decode stall:** same as late data but `ds_allowin=0` for 4 cycles → inst held. Valid stays 1 with inst=0x8c220000 throughout, and `fs_allowin=0`.
- **Flush with two outstanding:** `fs_waiting=1`, `pfs_inst_waiting=1`, assert `do_flush` →
  - `drop_cnt=2`.
  - Next two data_ok are dropped, with `fs_inst_unable=0`.
  - The third data_ok sees `fs_inst_unable=1`.
- **Flush coincident with data_ok:** `fs_waiting=1`, `drop_cnt=0`, data_ok and flush in the same cycle → `drop_cnt` stays 0 and `fs_to_ds_valid=0`.
- **Exception record:** accept ex=1, excode=0x04, badvaddr=0xbfc00002 → passes to decode the next cycle with inst=0, never waits for data, and `fs_inst_unable=1`.
